// File: rtl/game_state_bridge.sv
// Display-side bridge for the game registers. It latches the ball position and winner once per frame
// and runs the round-over hold. Define GAME_BRIDGE_CLAMP_EN to clamp captured positions to the ball limits.
module game_state_bridge #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int BALL_SIZE       = 8,
  parameter int WIN_HOLD_FRAMES = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  input  logic [1:0]  winner,
  output logic [9:0]  ball_xlim,
  output logic [8:0]  ball_ylim,
  output logic [9:0]  disp_ball_x,
  output logic [8:0]  disp_ball_y,
  output logic        disp_valid,
  output logic [1:0]  disp_winner,
  output logic        round_over,
  output logic [15:0] frame_count
);

  localparam int CW = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [9:0]    XLIM      = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0]    YLIM      = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [CW-1:0] HOLD_INIT = CW'(WIN_HOLD_FRAMES);

  typedef enum logic [1:0] {PLAY, HOLD, WAIT_CLEAR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    w;
  logic [9:0]    cap_x;
  logic [8:0]    cap_y;

  // Code 3 is not a real winner and behaves as "none".
  always_comb begin
    w = (winner == 2'd3) ? 2'd0 : winner;
  end

`ifdef GAME_BRIDGE_CLAMP_EN
  always_comb begin
    cap_x = (ball_x > XLIM) ? XLIM : ball_x;
    cap_y = (ball_y > YLIM) ? YLIM : ball_y;
  end
`else
  always_comb begin
    cap_x = ball_x;
    cap_y = ball_y;
  end
`endif

  // Limits sit at their constants in and out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ball_xlim <= XLIM;
      ball_ylim <= YLIM;
    end else begin
      ball_xlim <= XLIM;
      ball_ylim <= YLIM;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_start) begin
      unique case (state)
        PLAY:       if (w != 2'd0) state_next = HOLD;
        HOLD:       if (hold_cnt == CW'(1)) state_next = (w != 2'd0) ? WAIT_CLEAR : PLAY;
        WAIT_CLEAR: if (w == 2'd0) state_next = PLAY;
        default:    state_next = PLAY;
      endcase
    end
  end

  always_comb begin
    round_over = (state != PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_ball_x <= '0;
      disp_ball_y <= '0;
      disp_valid  <= 1'b0;
      disp_winner <= '0;
      frame_count <= '0;
      hold_cnt    <= '0;
    end else if (frame_start) begin
      disp_ball_x <= cap_x;
      disp_ball_y <= cap_y;
      disp_valid  <= 1'b1;
      frame_count <= frame_count + 16'd1;
      // disp_winner is loaded only on entry to HOLD and cleared on every return to PLAY.
      if (state == PLAY && state_next == HOLD) begin
        disp_winner <= w;
        hold_cnt    <= HOLD_INIT;
      end else if (state_next == PLAY) begin
        disp_winner <= '0;
      end
      if (state == HOLD) hold_cnt <= hold_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_game_state_bridge.sv
// Scoreboard bench for game_state_bridge with WIN_HOLD_FRAMES=3; expected outputs are queued per frame_start.
module tb_game_state_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [9:0]  ball_x;
  logic [8:0]  ball_y;
  logic [1:0]  winner;
  logic [9:0]  ball_xlim;
  logic [8:0]  ball_ylim;
  logic [9:0]  disp_ball_x;
  logic [8:0]  disp_ball_y;
  logic        disp_valid;
  logic [1:0]  disp_winner;
  logic        round_over;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        v;
    logic [1:0]  win;
    logic        ro;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 play, 1 hold, 2 waiting for winner to clear.
  int          m_state;
  int          m_hold;
  logic [1:0]  m_win;
  logic [15:0] m_fc;

  game_state_bridge #(
    .SCREEN_W(640),
    .SCREEN_H(480),
    .BALL_SIZE(8),
    .WIN_HOLD_FRAMES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_start(frame_start),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .winner(winner),
    .ball_xlim(ball_xlim),
    .ball_ylim(ball_ylim),
    .disp_ball_x(disp_ball_x),
    .disp_ball_y(disp_ball_y),
    .disp_valid(disp_valid),
    .disp_winner(disp_winner),
    .round_over(round_over),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_hold  = 0;
    m_win   = 2'd0;
    m_fc    = 16'd0;
  endtask

  task automatic push_expected(input logic [9:0] x, input logic [8:0] y, input logic [1:0] wr);
    exp_t e;
    logic [1:0] w;
    w = (wr == 2'd3) ? 2'd0 : wr;
    m_fc = m_fc + 16'd1;
    case (m_state)
      0: if (w != 2'd0) begin
           m_win   = w;
           m_hold  = 3;
           m_state = 1;
         end
      1: begin
           m_hold = m_hold - 1;
           if (m_hold == 0) begin
             if (w != 2'd0) m_state = 2;
             else begin
               m_state = 0;
               m_win   = 2'd0;
             end
           end
         end
      default: if (w == 2'd0) begin
                 m_state = 0;
                 m_win   = 2'd0;
               end
    endcase
`ifdef GAME_BRIDGE_CLAMP_EN
    e.x = (x > 10'd632) ? 10'd632 : x;
    e.y = (y > 9'd472) ? 9'd472 : y;
`else
    e.x = x;
    e.y = y;
`endif
    e.v   = 1'b1;
    e.win = m_win;
    e.ro  = (m_state != 0);
    e.fc  = m_fc;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("disp_ball_x", disp_ball_x, e.x);
      check("disp_ball_y", disp_ball_y, e.y);
      check("disp_valid", disp_valid, e.v);
      check("disp_winner", disp_winner, e.win);
      check("round_over", round_over, e.ro);
      check("frame_count", frame_count, e.fc);
    end
  endtask

  // Drives one frame_start cycle; back-to-back calls give consecutive pulses.
  task automatic frame(input logic [9:0] x, input logic [8:0] y, input logic [1:0] w);
    ball_x      = x;
    ball_y      = y;
    winner      = w;
    frame_start = 1'b1;
    push_expected(x, y, w);
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    pop_compare();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    ball_x = '0;
    ball_y = '0;
    winner = '0;
    model_reset();
    #1;
    check("rst_round_over", round_over, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_disp_valid", disp_valid, 0);
    @(posedge clock);
    #1;
    check("rst_xlim", ball_xlim, 632);
    check("rst_ylim", ball_ylim, 472);
    @(negedge clock);
    reset = 1'b0;
    idle(4);
    check("idle_disp_valid", disp_valid, 0);
    check("idle_disp_x", disp_ball_x, 0);
    check("idle_disp_winner", disp_winner, 0);
    check("idle_xlim", ball_xlim, 632);
    check("idle_ylim", ball_ylim, 472);

    // Capture and hold between frames.
    frame(10'd100, 9'd50, 2'd0);
    check("cap_x100", disp_ball_x, 100);
    check("cap_fc1", frame_count, 1);
    ball_x = 10'd200;
    winner = 2'd1;
    idle(3);
    check("no_frame_x", disp_ball_x, 100);
    check("no_frame_ro", round_over, 0);

    // Right wins, then three frames of hold.
    frame(10'd120, 9'd60, 2'd2);
    check("win2_ro", round_over, 1);
    check("win2_dw", disp_winner, 2);
    frame(10'd121, 9'd61, 2'd0);
    idle(2);
    frame(10'd122, 9'd62, 2'd1);
    check("hold_ignores_winner", disp_winner, 2);
    frame(10'd123, 9'd63, 2'd0);
    check("hold_expired_ro", round_over, 0);
    check("hold_expired_dw", disp_winner, 0);

    // Left wins and keeps winning through expiry, then clears.
    frame(10'd5, 9'd6, 2'd1);
    frame(10'd5, 9'd6, 2'd1);
    frame(10'd5, 9'd6, 2'd1);
    frame(10'd5, 9'd6, 2'd1);
    check("wait_clear_ro", round_over, 1);
    frame(10'd5, 9'd6, 2'd2);
    check("wait_clear_dw", disp_winner, 1);
    frame(10'd7, 9'd8, 2'd0);
    check("cleared_ro", round_over, 0);
    check("cleared_dw", disp_winner, 0);

    // Invalid winner code and boundary positions.
    frame(10'd631, 9'd471, 2'd3);
    check("win3_ro", round_over, 0);
    frame(10'd632, 9'd472, 2'd0);
    frame(10'd700, 9'd500, 2'd0);
    frame(10'd1023, 9'd511, 2'd0);
    for (int i = 0; i < 6; i++) begin
      frame(10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
    end
    while (m_state != 0) frame(10'd1, 9'd1, 2'd0);

    // Reset in the middle of a hold.
    frame(10'd300, 9'd200, 2'd2);
    frame(10'd300, 9'd200, 2'd0);
    check("pre_reset_ro", round_over, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ro", round_over, 0);
    check("async_rst_fc", frame_count, 0);
    check("async_rst_dw", disp_winner, 0);
    check("async_rst_valid", disp_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    frame(10'd9, 9'd9, 2'd0);
    check("post_reset_fc", frame_count, 1);
    check("post_reset_ro", round_over, 0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_bridge.md
# game_state_bridge

Display-side counterpart of the processor's game-register interface. Samples the ball position and winner code that the regfile exports once per video frame, and presents a stable, frame-aligned copy to the renderer. Runs the round-over hold sequence and drives the ball limit values back into the regfile. Sits between the CPU/regfile subsystem and the VGA renderer on the single system clock.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- WIN_HOLD_FRAMES, 120, frames the winner banner is held (must be ≥1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- ball_x  in  10  ball x from regfile (CPU-written)
- ball_y  in  9  ball y from regfile
- winner  in  2  winner code from regfile: 0 none, 1 left, 2 right, 3 invalid (treated as 0)
- ball_xlim  out  10  maximum legal ball x, to regfile
- ball_ylim  out  9  maximum legal ball y, to regfile
- disp_ball_x  out  10  frame-latched ball x for renderer
- disp_ball_y  out  9  frame-latched ball y for renderer
- disp_valid  out  1  at least one frame captured since reset
- disp_winner  out  2  latched winner code (1 or 2) while round_over, else 0
- round_over  out  1  winner banner active
- frame_count  out  16  frame_start counter, wraps

## Operation
- ball_xlim = SCREEN_W − BALL_SIZE (632 default), ball_ylim = SCREEN_H − BALL_SIZE (472). Both are registered and hold these values continuously, including during reset.
- Capture: on every frame_start cycle, in every state, disp_ball_x/y ← ball_x/y (see Configuration), disp_valid ← 1, frame_count ← frame_count+1 mod 2^16.
- Effective winner w = winner, except 3 maps to 0.
- FSM states:
  - PLAY: round_over=0, disp_winner=0. On frame_start with w≠0: latch disp_winner←w, load hold counter with WIN_HOLD_FRAMES, go to HOLD.
  - HOLD: round_over=1. On each frame_start, decrement the counter. When the decrement yields 0: go to WAIT_CLEAR if w≠0 in that cycle, else go to PLAY. winner changes are ignored for disp_winner.
  - WAIT_CLEAR: round_over=1. On frame_start with w=0, go to PLAY (disp_winner←0).
- Winner changes between frame_starts are never observed; only the sampled value matters.
- Hold counter width is $clog2(WIN_HOLD_FRAMES+1).

## Timing
- Reset values: disp_ball_x=0, disp_ball_y=0, disp_valid=0, disp_winner=0, round_over=0, frame_count=0, state PLAY, hold counter 0; ball_xlim/ylim at their constants.
- Latency: the frame_start cycle samples the inputs; all outputs update on that edge and are visible the next cycle. Latency is 1 clock.
- Outputs change only on frame_start edges (apart from reset), so they are stable for the whole active video period.
- frame_start asserted on consecutive cycles: each cycle counts as a separate frame.
- Reset asserted mid-HOLD: immediately returns to PLAY with reset values; no residual hold.
- frame_count wraps 0xFFFF→0x0000 with no side effects.
- Exit from PLAY to PLAY in the same frame as HOLD expiry is not possible; a new win requires one frame_start in PLAY.

## Configuration
- GAME_BRIDGE_CLAMP_EN defined: captured positions are clamped. disp_ball_x = min(ball_x, ball_xlim), disp_ball_y = min(ball_y, ball_ylim), unsigned compare.
- Not defined: raw ball_x/ball_y are captured unmodified; the comparators are absent.

## Test plan
(WIN_HOLD_FRAMES=3, default screen parameters)
- Reset then idle: no frame_start -> all outputs at reset values; ball_xlim=632, ball_ylim=472; disp_valid=0.
- ball_x=100, ball_y=50, pulse frame_start -> next cycle disp_ball_x=100, disp_ball_y=50, disp_valid=1, frame_count=1. Changing ball_x to 200 without frame_start -> disp_ball_x stays 100.
- winner=2 at frame_start -> round_over=1, disp_winner=2. winner=0 thereafter -> round_over drops after exactly the 3rd subsequent frame_start.
- winner held at 1 through hold expiry -> state WAIT_CLEAR, round_over stays 1. First frame_start with winner=0 -> round_over=0, disp_winner=0.
- winner=3 at frame_start -> stays PLAY, round_over=0. Reset asserted mid-HOLD -> round_over=0, frame_count=0 asynchronously.
- With GAME_BRIDGE_CLAMP_EN: ball_x=700, ball_y=500 -> disp 632/472. Without it -> disp 700/500.
